// File: rtl/gray_updown_nbits_if.sv
// Control and status bundle for the up/down Gray counter.
// The master drives the count controls; the slave returns registered state.
interface gray_updown_nbits_if #(
   parameter int N = 8
);
   logic         clk_en;
   logic         up_dn;
   logic         load;
   logic [N-1:0] load_val;
   logic [N-1:0] gray_out;
   logic [N-1:0] bin_out;
   logic         at_max;
   logic         at_zero;
   logic         bound;

   modport master (
      output clk_en, up_dn, load, load_val,
      input  gray_out, bin_out, at_max, at_zero, bound
   );

   modport slave (
      input  clk_en, up_dn, load, load_val,
      output gray_out, bin_out, at_max, at_zero, bound
   );
endinterface

// File: rtl/gray_updown_nbits.sv
// Up/down Gray counter with load, wrap/saturate mode and boundary pulse.
// A binary count is kept alongside a registered Gray encode of the next count.
module gray_updown_nbits #(
   parameter int N    = 8,
   parameter bit WRAP = 1'b1
) (
   input logic              clk,
   input logic              rst,
   gray_updown_nbits_if.slave bus
);

   if (N < 2 || N > 32) begin : g_bad_n
      $error("gray_updown_nbits: N must be in 2..32");
   end

   localparam logic [N-1:0] MAX = '1;
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] bin_q, bin_d;
   logic [N-1:0] gray_q, gray_d;
   logic         at_max_q, at_max_d;
   logic         at_zero_q, at_zero_d;
   logic         bound_q, bound_d;
   logic [N-1:0] load_bin;

   always_comb begin
      load_bin        = '0;
      load_bin[N-1]   = bus.load_val[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         load_bin[i] = load_bin[i+1] ^ bus.load_val[i];
      end
   end

   always_comb begin
      bin_d   = bin_q;
      bound_d = 1'b0;
      if (bus.load) begin
         bin_d = load_bin;
      end else if (bus.clk_en) begin
         if (bus.up_dn) begin
            if (bin_q == MAX) begin
               bound_d = 1'b1;
               if (WRAP) bin_d = '0;
            end else begin
               bin_d = bin_q + ONE;
            end
         end else begin
            if (bin_q == '0) begin
               bound_d = 1'b1;
               if (WRAP) bin_d = MAX;
            end else begin
               bin_d = bin_q - ONE;
            end
         end
      end
      // Flags come from the next count so they line up with gray_q.
      gray_d    = bin_d ^ (bin_d >> 1);
      at_max_d  = (bin_d == MAX);
      at_zero_d = (bin_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q     <= '0;
         gray_q    <= '0;
         at_max_q  <= 1'b0;
         at_zero_q <= 1'b1;
         bound_q   <= 1'b0;
      end else begin
         bin_q     <= bin_d;
         gray_q    <= gray_d;
         at_max_q  <= at_max_d;
         at_zero_q <= at_zero_d;
         bound_q   <= bound_d;
      end
   end

   assign bus.gray_out = gray_q;
   assign bus.bin_out  = bin_q;
   assign bus.at_max   = at_max_q;
   assign bus.at_zero  = at_zero_q;
   assign bus.bound    = bound_q;

endmodule
